// File: rtl/sync_fifo_read_stage_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_read_stage_pkg
//
// Shared definitions for the FIFO read-side adapter:
//   STAGE_DEPTH        - number of words the output buffer can hold
//   FIFO_READ_LATENCY  - cycles from FIFO rd_en to valid dout
//   occ_e              - buffer occupancy encoding (EMPTY / ONE / TWO)
//   room_for_read()    - credit test used to decide whether a new FIFO read
//                        may be launched this cycle
// ---------------------------------------------------------------------------
package sync_fifo_read_stage_pkg;

  localparam int STAGE_DEPTH       = 2;
  localparam int FIFO_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Words already committed to the buffer after this cycle (held + in flight
  // - leaving) must leave room for one more. A pop implies occ >= 1, so the
  // subtraction never wraps; three bits cover the worst-case sum of 3.
  function automatic logic room_for_read(input occ_e occ,
                                         input logic inflight,
                                         input logic pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (committed < 3'(STAGE_DEPTH));
  endfunction

endpackage : sync_fifo_read_stage_pkg

// File: rtl/sync_fifo_read_stage_buffer.sv
// ---------------------------------------------------------------------------
// skid_buffer_2entry
//
// Two-entry output buffer with a registered valid/ready output.
// 'head' is the output register, 'tail' the skid register. Words arrive on
// the 'capture' strobe (no backpressure on that side: the upstream credit
// logic guarantees a free slot) and leave on 'pop'.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active low
//   capture       in   capture_data is valid this cycle and must be stored
//   capture_data  in   word to store
//   out_ready     in   consumer accepts the head word
//   out_valid     out  head holds a word (decoded from registered occ)
//   out_data      out  head word (registered)
//   occ           out  current occupancy
//   pop           out  out_valid && out_ready, exported for credit logic
// ---------------------------------------------------------------------------
module skid_buffer_2entry
  import sync_fifo_read_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] capture_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output occ_e                  occ,
  output logic                  pop
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  assign out_valid = (occ != OCC_EMPTY);
  assign out_data  = head;
  assign pop       = out_valid && out_ready;

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees the pre-edge values of its neighbours (tail -> head
  // and capture -> tail happen on the same edge without ordering hazards).
  // NOTE: head/tail are reset even though they are data, because out_data
  // has a defined reset value of zero; with only two entries this is cheap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (capture) begin
            head <= capture_data;
            occ  <= OCC_ONE;
          end
        end

        OCC_ONE: begin
          if (capture && pop) begin
            // head leaves and is replaced in the same edge; stays valid.
            head <= capture_data;
          end else if (capture) begin
            tail <= capture_data;
            occ  <= OCC_TWO;
          end else if (pop) begin
            occ  <= OCC_EMPTY;
          end
        end

        OCC_TWO: begin
          // Capture without pop cannot happen here: the read was only
          // launched if a slot would be free on arrival.
          if (pop) begin
            head <= tail;
            if (capture) begin
              tail <= capture_data;
            end else begin
              occ  <= OCC_ONE;
            end
          end
        end

        default: occ <= OCC_EMPTY;
      endcase
    end
  end

endmodule : skid_buffer_2entry

// File: rtl/sync_fifo_read_stage.sv
// ---------------------------------------------------------------------------
// sync_fifo_read_stage
//
// Read-side adapter for a standard (1-cycle read latency) synchronous FIFO.
// Issues fifo_rd_en whenever the FIFO has data and the output buffer will
// have room when the word lands, tracks the word in flight, and presents a
// bubble-free registered valid/ready stream.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   fifo_empty   in   FIFO empty flag
//   fifo_dout    in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   out  FIFO read strobe (combinational from out_ready)
//   out_valid    out  output word available (registered)
//   out_data     out  output word (registered)
//   out_ready    in   consumer ready
//   stage_count  out  words held plus word in flight (0..2)
// ---------------------------------------------------------------------------
module sync_fifo_read_stage
  import sync_fifo_read_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            stage_count
);

  // Registered fifo_rd_en: fifo_dout carries a word this cycle.
  logic inflight;
  occ_e occ;
  logic pop;

  skid_buffer_2entry #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buffer (
    .clk          (clk),
    .rst          (rst),
    .capture      (inflight),
    .capture_data (fifo_dout),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .occ          (occ),
    .pop          (pop)
  );

  // Gating with rst keeps the FIFO untouched while the stage is held in
  // reset, whatever fifo_empty says. Only out_ready (via pop) reaches this
  // output combinationally; fifo_dout never does.
  assign fifo_rd_en = rst && !fifo_empty && room_for_read(occ, inflight, pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // occ + inflight never exceeds STAGE_DEPTH, so two bits suffice.
  assign stage_count = occ + {1'b0, inflight};

endmodule : sync_fifo_read_stage

// File: tb/tb_sync_fifo_read_stage.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_read_stage
//
// Self-checking bench: a behavioural FIFO (array + pointers, 1-cycle read
// latency) feeds the DUT; a queue of written words is the reference for the
// output stream, and read/pop counters give the expected stage_count and
// the allowed read strobe.
// ---------------------------------------------------------------------------
module tb_sync_fifo_read_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    stage_count;

  always #5 clk = ~clk;

  sync_fifo_read_stage #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .stage_count (stage_count)
  );

  // ---------------- behavioural FIFO ----------------
  logic [DW-1:0] mem [256];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          empty_mask = 1'b0;

  assign fifo_empty = (wr_ptr <= rd_ptr) || empty_mask;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] exp_q [$];
  int            n_read = 0;
  int            n_pop  = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          s_rd, s_valid, s_pop;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // Evaluate one cycle: inputs are already driven; sample 1 ns later, then
  // advance to the next falling edge for the caller to drive again.
  task automatic cycle();
    logic exp_rd;
    int   committed;
    #1;
    s_rd    = fifo_rd_en;
    s_valid = out_valid;
    s_pop   = out_valid && out_ready;
    committed = n_read - n_pop;
    check("stage_count", 32'(stage_count), 32'(committed));
    check("stage_max", 32'(stage_count <= 2), 32'd1);
    exp_rd = !fifo_empty && ((committed - int'(s_pop)) < 2);
    check("rd_en_rule", 32'(fifo_rd_en), 32'(exp_rd));
    if (hold_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, prev_data);
    end
    if (s_pop) begin
      if (exp_q.size() == 0) check("spurious_pop", 32'd1, 32'd0);
      else                   check("out_data", out_data, exp_q.pop_front());
    end
    if (fifo_rd_en) n_read++;
    if (s_pop)      n_pop++;
    hold_prev = out_valid && !out_ready;
    prev_data = out_data;
    @(negedge clk);
  endtask

  task automatic clear_model();
    wr_ptr = rd_ptr;  // resets the behavioural FIFO alongside the stage
    exp_q.delete();
    n_read    = 0;
    n_pop     = 0;
    hold_prev = 1'b0;
  endtask

  initial begin : main
    int rd_cnt, v_cnt, first_v, last_v;

    // ---- reset behaviour: fifo_empty ignored while in reset ----
    rst = 1'b0;
    out_ready = 1'b1;
    push(32'hDEAD_BEEF);
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_count", 32'(stage_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear_model();
    rst = 1'b1;
    @(negedge clk);

    // ---- single word: rd_en once, out_valid exactly at T+2 ----
    push(32'hA5A5_0001);
    rd_cnt = 0; v_cnt = 0; first_v = -1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (s_rd) rd_cnt++;
      if (s_valid) begin v_cnt++; if (first_v < 0) first_v = k; end
    end
    check("t1_rd_pulses", 32'(rd_cnt), 32'd1);
    check("t1_valid_cycles", 32'(v_cnt), 32'd1);
    check("t1_latency", 32'(first_v), 32'd2);

    // ---- 16 words, full throughput ----
    for (int i = 0; i < 16; i++) push(32'(i));
    v_cnt = 0; first_v = -1; last_v = -1;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (s_pop) begin v_cnt++; if (first_v < 0) first_v = k; last_v = k; end
    end
    check("t2_words", 32'(v_cnt), 32'd16);
    check("t2_no_gaps", 32'(last_v - first_v), 32'd15);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // ---- backpressure: 8 words, ready low for 10 cycles ----
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'(i));
    rd_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_rd) rd_cnt++;
    end
    check("t3_reads", 32'(rd_cnt), 32'd2);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_held_data", out_data, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // ---- 32 words, ready alternating ----
    for (int i = 0; i < 32; i++) push(32'h100 + 32'(i));
    for (int k = 0; k < 80; k++) begin
      out_ready = (k % 2 == 0);
      cycle();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // ---- reset with two words buffered ----
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i));
    for (int k = 0; k < 4; k++) cycle();
    check("t5_full", 32'(stage_count), 32'd2);
    rst = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_data", out_data, 32'd0);
    check("t5_rst_count", 32'(stage_count), 32'd0);
    check("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    push(32'h0000_1234);
    v_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (s_pop) v_cnt++;
    end
    check("t5_one_word", 32'(v_cnt), 32'd1);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // ---- fifo_empty toggling every cycle ----
    for (int i = 0; i < 20; i++) push(32'h300 + 32'(i));
    for (int k = 0; k < 60; k++) begin
      empty_mask = (k % 2 == 1);
      cycle();
    end
    empty_mask = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    // ---- randomized traffic ----
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) != 0 && (wr_ptr - rd_ptr) < 200) push($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      empty_mask = ($urandom_range(0, 4) == 0);
      cycle();
    end
    empty_mask = 1'b0;
    out_ready  = 1'b1;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) cycle();
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sync_fifo_read_stage
